// File: rtl/am_lock_rx.sv
// am_lock_rx
// ----------
// Alignment-marker lock for one PCS lane of a 64b/66b receiver. Each incoming
// block is registered straight through to the output with one cycle of latency.
// Alongside it the block is compared against the lane's alignment marker, and a
// small state machine (SEARCH -> CONFIRM -> LOCKED) tracks the marker period.
// The lock result feeds the downstream deskew stage.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   valid_i        in   data_i carries a block this cycle
//   block_lock_i   in   upstream block-sync lock level
//   data_i         in   received block; [65:64] is the sync header
//   valid_o        out  data_o valid (registered valid_i)
//   data_o         out  registered copy of data_i; holds while valid_i is low
//   am_v_o         out  data_o is an accepted alignment marker
//   lock_v_o       out  marker lock level
//   lock_lost_v_o  out  one-cycle pulse when an established lock is lost
module am_lock_rx #(
  parameter int BLOCK_W   = 66,
  parameter int LANE_ID   = 0,
  parameter int AM_PERIOD = 16384,
  parameter int AM_BAD_N  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic               block_lock_i,
  input  logic [BLOCK_W-1:0] data_i,
  output logic               valid_o,
  output logic [BLOCK_W-1:0] data_o,
  output logic               am_v_o,
  output logic               lock_v_o,
  output logic               lock_lost_v_o
);

  localparam int CNT_W = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
  localparam int BAD_W = (AM_BAD_N > 0) ? $clog2(AM_BAD_N + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(AM_BAD_N - 1);
  localparam logic [BAD_W-1:0] BAD_ONE  = BAD_W'(1);
  localparam logic [BAD_W-1:0] BAD_ZERO = {BAD_W{1'b0}};

  localparam logic [1:0]  AM_SYNC     = 2'b10;
  // BIP3 (bits 31:24) and BIP7 (bits 63:56) carry parity, not marker pattern
  localparam logic [63:0] MARKER_MASK = 64'h00FF_FFFF_00FF_FFFF;
  localparam logic [1:0]  LANE_SEL    = 2'(LANE_ID);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Marker payload per lane, bytes M0..M6 packed LSB first, BIP slots zero
  function automatic logic [63:0] lane_marker(input logic [1:0] lane);
    logic [63:0] m;
    case (lane)
      2'd0:    m = 64'h00B8_896F_0047_7690;
      2'd1:    m = 64'h0019_3B0F_00E6_C4F0;
      2'd2:    m = 64'h0064_9A3A_009B_65C5;
      2'd3:    m = 64'h00C2_865D_003D_79A2;
      default: m = 64'h00B8_896F_0047_7690;
    endcase
    return m;
  endfunction

  // True when the block carries this lane's marker, ignoring the BIP bytes
  function automatic logic is_marker(input logic [BLOCK_W-1:0] blk);
    logic hdr_ok;
    logic pat_ok;
    hdr_ok = (blk[BLOCK_W-1 -: 2] == AM_SYNC);
    pat_ok = ((blk[63:0] & MARKER_MASK) == (lane_marker(LANE_SEL) & MARKER_MASK));
    return hdr_ok & pat_ok;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [BAD_W-1:0] r_bad;

  logic             w_match;
  logic             w_at_exp;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_match   = valid_i & is_marker(data_i);
  // r_cnt counts valid blocks since the last marker slot; the slot itself is 0
  assign w_at_exp  = (r_cnt == CNT_LAST);
  assign w_cnt_inc = w_at_exp ? CNT_ZERO : (r_cnt + CNT_ONE);

  // Data pipeline, marker lock state machine and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_SEARCH;
      r_cnt         <= CNT_ZERO;
      r_bad         <= BAD_ZERO;
      valid_o       <= 1'b0;
      data_o        <= {BLOCK_W{1'b0}};
      am_v_o        <= 1'b0;
      lock_v_o      <= 1'b0;
      lock_lost_v_o <= 1'b0;
    end else begin
      valid_o       <= valid_i;
      am_v_o        <= 1'b0;
      lock_lost_v_o <= 1'b0;
      // Lock rises one cycle after the confirming marker; falls are forced below
      lock_v_o      <= (r_state == ST_LOCKED);

      if (valid_i) begin
        data_o <= data_i;
      end else begin
        data_o <= data_o;
      end

      if (!block_lock_i) begin
        // Upstream lost block sync: overrides any marker seen this cycle
        r_state       <= ST_SEARCH;
        r_cnt         <= CNT_ZERO;
        r_bad         <= BAD_ZERO;
        lock_v_o      <= 1'b0;
        lock_lost_v_o <= (r_state == ST_LOCKED);
      end else if (valid_i) begin
        case (r_state)
          ST_SEARCH: begin
            r_cnt <= CNT_ZERO;
            r_bad <= BAD_ZERO;
            if (w_match) begin
              r_state <= ST_CONFIRM;
              am_v_o  <= 1'b1;
            end else begin
              r_state <= ST_SEARCH;
            end
          end

          ST_CONFIRM: begin
            r_cnt <= w_cnt_inc;
            if (w_at_exp && w_match) begin
              r_state <= ST_LOCKED;
              am_v_o  <= 1'b1;
            end else if (w_at_exp) begin
              // Failed confirmation; this block is not reused as a candidate
              r_state <= ST_SEARCH;
            end else begin
              r_state <= ST_CONFIRM;
            end
          end

          ST_LOCKED: begin
            r_cnt <= w_cnt_inc;
            if (w_at_exp && w_match) begin
              r_bad  <= BAD_ZERO;
              am_v_o <= 1'b1;
            end else if (w_at_exp && (r_bad == BAD_LAST)) begin
              r_state       <= ST_SEARCH;
              r_cnt         <= CNT_ZERO;
              r_bad         <= BAD_ZERO;
              lock_v_o      <= 1'b0;
              lock_lost_v_o <= 1'b1;
            end else if (w_at_exp) begin
              r_bad <= r_bad + BAD_ONE;
            end else begin
              r_bad <= r_bad;
            end
          end

          default: begin
            r_state <= ST_SEARCH;
            r_cnt   <= CNT_ZERO;
            r_bad   <= BAD_ZERO;
          end
        endcase
      end else begin
        // No block this cycle: hold position and state
        r_state <= r_state;
        r_cnt   <= r_cnt;
        r_bad   <= r_bad;
      end
    end
  end

endmodule

// File: tb/tb_am_lock_rx.sv
// Directed bench for am_lock_rx with AM_PERIOD=16, LANE_ID=1, AM_BAD_N=4.
// Each block is driven on the falling edge and its registered result is
// sampled 1 ns after the following rising edge.
module tb_am_lock_rx;

  localparam int BW = 66;

  // Block kinds
  localparam int K_FILL = 0;  // header 01, random payload
  localparam int K_AM1  = 1;  // lane1 marker, random BIP bytes
  localparam int K_BAD  = 2;  // lane1 marker with M0 altered
  localparam int K_AM0  = 3;  // lane0 marker
  localparam int K_H01  = 4;  // lane1 marker pattern behind header 01

  logic          clk;
  logic          reset;
  logic          valid_i;
  logic          block_lock_i;
  logic [BW-1:0] data_i;
  logic          valid_o;
  logic [BW-1:0] data_o;
  logic          am_v_o;
  logic          lock_v_o;
  logic          lock_lost_v_o;

  int            n_checks;
  int            n_err;
  logic [BW-1:0] last_d;

  am_lock_rx #(
    .BLOCK_W  (66),
    .LANE_ID  (1),
    .AM_PERIOD(16),
    .AM_BAD_N (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .block_lock_i (block_lock_i),
    .data_i       (data_i),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .am_v_o       (am_v_o),
    .lock_v_o     (lock_v_o),
    .lock_lost_v_o(lock_lost_v_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] mk(input int kind);
    logic [31:0]   r0;
    logic [31:0]   r1;
    logic [BW-1:0] d;
    r0 = $urandom;
    r1 = $urandom;
    case (kind)
      K_AM1:   d = {2'b10, r0[7:0], 8'h19, 8'h3B, 8'h0F, r0[15:8], 8'hE6, 8'hC4, 8'hF0};
      K_BAD:   d = {2'b10, r0[7:0], 8'h19, 8'h3B, 8'h0F, r0[15:8], 8'hE6, 8'hC4, 8'hF1};
      K_AM0:   d = {2'b10, r0[7:0], 8'hB8, 8'h89, 8'h6F, r0[15:8], 8'h47, 8'h76, 8'h90};
      K_H01:   d = {2'b01, r0[7:0], 8'h19, 8'h3B, 8'h0F, r0[15:8], 8'hE6, 8'hC4, 8'hF0};
      default: d = {2'b01, r0, r1};
    endcase
    return d;
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One valid block; checks the output cycle it produces
  task automatic blk(input int kind, input logic bl, input logic e_am,
                     input logic e_lock, input logic e_lost, input string tag);
    logic [BW-1:0] d;
    d = mk(kind);
    @(negedge clk);
    valid_i      = 1'b1;
    block_lock_i = bl;
    data_i       = d;
    last_d       = d;
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {65'd0, valid_o}, {65'd0, 1'b1});
    chk({tag, ".data"}, data_o, d);
    chk({tag, ".am"}, {65'd0, am_v_o}, {65'd0, e_am});
    chk({tag, ".lock"}, {65'd0, lock_v_o}, {65'd0, e_lock});
    chk({tag, ".lost"}, {65'd0, lock_lost_v_o}, {65'd0, e_lost});
  endtask

  task automatic fill(input int n, input logic e_lock, input string tag);
    for (int i = 0; i < n; i++) begin
      blk(K_FILL, 1'b1, 1'b0, e_lock, 1'b0, tag);
    end
  endtask

  // Idle cycles; the driven data is a marker so it must be ignored
  task automatic gap(input int n, input logic e_lock, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_i      = 1'b0;
      block_lock_i = 1'b1;
      data_i       = mk(K_AM1);
      @(posedge clk);
      #1;
      chk({tag, ".valid"}, {65'd0, valid_o}, {65'd0, 1'b0});
      chk({tag, ".data_hold"}, data_o, last_d);
      chk({tag, ".am"}, {65'd0, am_v_o}, {65'd0, 1'b0});
      chk({tag, ".lock"}, {65'd0, lock_v_o}, {65'd0, e_lock});
      chk({tag, ".lost"}, {65'd0, lock_lost_v_o}, {65'd0, 1'b0});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, {65'd0, valid_o}, {BW{1'b0}});
    chk({tag, ".data"}, data_o, {BW{1'b0}});
    chk({tag, ".am"}, {65'd0, am_v_o}, {BW{1'b0}});
    chk({tag, ".lock"}, {65'd0, lock_v_o}, {BW{1'b0}});
    chk({tag, ".lost"}, {65'd0, lock_lost_v_o}, {BW{1'b0}});
  endtask

  initial begin
    n_checks     = 0;
    n_err        = 0;
    last_d       = {BW{1'b0}};
    reset        = 1'b1;
    valid_i      = 1'b0;
    block_lock_i = 1'b1;
    data_i       = {BW{1'b0}};

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    // Markers at blocks 0 and 16 -> lock; non-expected marker ignored
    blk(K_AM1, 1'b1, 1'b1, 1'b0, 1'b0, "acq.m0");
    fill(15, 1'b0, "acq.f");
    blk(K_AM1, 1'b1, 1'b1, 1'b0, 1'b0, "acq.m16");
    blk(K_FILL, 1'b1, 1'b0, 1'b1, 1'b0, "acq.rise");
    fill(14, 1'b1, "lk.f");
    blk(K_AM1, 1'b1, 1'b1, 1'b1, 1'b0, "lk.m32");
    fill(7, 1'b1, "lk.f");
    blk(K_AM1, 1'b1, 1'b0, 1'b1, 1'b0, "lk.offslot");
    fill(7, 1'b1, "lk.f");

    // Three misses then a good marker keeps lock
    blk(K_BAD, 1'b1, 1'b0, 1'b1, 1'b0, "bad1");
    fill(15, 1'b1, "bad.f");
    blk(K_AM0, 1'b1, 1'b0, 1'b1, 1'b0, "bad2.lane0");
    fill(15, 1'b1, "bad.f");
    blk(K_H01, 1'b1, 1'b0, 1'b1, 1'b0, "bad3.hdr01");
    fill(15, 1'b1, "bad.f");
    blk(K_AM1, 1'b1, 1'b1, 1'b1, 1'b0, "bad.recover");

    // Four consecutive misses drop lock
    for (int j = 0; j < 3; j++) begin
      fill(15, 1'b1, "drop.f");
      blk(K_BAD, 1'b1, 1'b0, 1'b1, 1'b0, "drop.miss");
    end
    fill(15, 1'b1, "drop.f");
    blk(K_AM0, 1'b1, 1'b0, 1'b0, 1'b1, "drop.lost");
    blk(K_FILL, 1'b1, 1'b0, 1'b0, 1'b0, "drop.after");

    // Failed confirmation, then reacquire at 20 and 36
    blk(K_AM1, 1'b1, 1'b1, 1'b0, 1'b0, "cf.m0");
    fill(15, 1'b0, "cf.f");
    blk(K_FILL, 1'b1, 1'b0, 1'b0, 1'b0, "cf.miss16");
    fill(3, 1'b0, "cf.f");
    blk(K_AM1, 1'b1, 1'b1, 1'b0, 1'b0, "cf.m20");
    fill(7, 1'b0, "cf.f");
    blk(K_AM1, 1'b1, 1'b0, 1'b0, 1'b0, "cf.offslot");
    fill(7, 1'b0, "cf.f");
    blk(K_AM1, 1'b1, 1'b1, 1'b0, 1'b0, "cf.m36");
    blk(K_FILL, 1'b1, 1'b0, 1'b1, 1'b0, "cf.rise");

    // Idle gap between markers does not advance the position
    fill(5, 1'b1, "gap.f");
    gap(5, 1'b1, "gap.idle");
    fill(9, 1'b1, "gap.f");
    blk(K_AM1, 1'b1, 1'b1, 1'b1, 1'b0, "gap.m");

    // block_lock_i drop wins over a same-cycle marker; one pulse only
    fill(3, 1'b1, "bl.f");
    blk(K_FILL, 1'b1, 1'b0, 1'b1, 1'b0, "bl.pre");
    fill(11, 1'b1, "bl.f");
    blk(K_AM1, 1'b0, 1'b0, 1'b0, 1'b1, "bl.drop");
    blk(K_AM1, 1'b0, 1'b0, 1'b0, 1'b0, "bl.low");
    blk(K_FILL, 1'b1, 1'b0, 1'b0, 1'b0, "bl.back");

    // Relock, then asynchronous reset mid-lock
    blk(K_AM1, 1'b1, 1'b1, 1'b0, 1'b0, "rl.m0");
    fill(15, 1'b0, "rl.f");
    blk(K_AM1, 1'b1, 1'b1, 1'b0, 1'b0, "rl.m16");
    fill(4, 1'b1, "rl.f");
    #2;
    reset = 1'b1;
    #1;
    chk_zero("arst");
    @(negedge clk);
    valid_i = 1'b0;
    reset   = 1'b0;
    #1;
    chk({"arst.rel", ".valid"}, {65'd0, valid_o}, {BW{1'b0}});
    chk({"arst.rel", ".lost"}, {65'd0, lock_lost_v_o}, {BW{1'b0}});
    blk(K_FILL, 1'b1, 1'b0, 1'b0, 1'b0, "arst.first");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/am_lock_rx.md
AM_LOCK_RX -- requirements
Module: am_lock_rx

Interface
REQ-001 Parameter BLOCK_W, 66, width of one 64b/66b block including 2-bit sync header.
REQ-002 Parameter LANE_ID, 0, expected PCS lane (0..3); selects the lane marker to match.
REQ-003 Parameter AM_PERIOD, 16384, valid blocks from one alignment marker to the next, marker included; legal range 4..16384.
REQ-004 Parameter AM_BAD_N, 4, consecutive missing expected markers that drop lock.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 valid_i  in  1  data_i carries a block this cycle.
REQ-008 block_lock_i  in  1  upstream block-sync lock level.
REQ-009 data_i  in  BLOCK_W  received block; bits [65:64] are the sync header.
REQ-010 valid_o  out  1  data_o valid.
REQ-011 data_o  out  BLOCK_W  registered copy of data_i.
REQ-012 am_v_o  out  1  data_o is an accepted alignment marker; feeds deskew am_lite_v_i.
REQ-013 lock_v_o  out  1  marker lock level; feeds deskew am_lite_lock_v_i.
REQ-014 lock_lost_v_o  out  1  one-cycle pulse on loss of lock; feeds deskew am_lite_lock_lost_v_i.

Function
REQ-015 Markers, sync header 2'b10, bytes M0..M6 (LSB first, BIP3 and BIP7 at bits [31:24] and [63:56]): lane0 90 76 47 / 6f 89 b8, lane1 f0 c4 e6 / 0f 3b 19, lane2 c5 65 9b / 3a 9a 64, lane3 a2 79 3d / 5d 86 c2.
REQ-016 Match = valid_i, sync header 2'b10, and all bits except [63:56] and [31:24] equal to the LANE_ID marker; BIP bytes are ignored.
REQ-017 Latency is exactly 1 cycle: valid_o, data_o, am_v_o are registered from valid_i, data_i, and the match decision of the same input cycle.
REQ-018 States: SEARCH, CONFIRM, LOCKED.
REQ-019 Block counter, width $clog2(AM_PERIOD), increments only on valid_i; wraps to 0 after AM_PERIOD-1; cleared on every state entry from a match.
REQ-020 SEARCH: match -> CONFIRM, counter cleared, am_v_o=1 for that block.
REQ-021 CONFIRM: block at counter AM_PERIOD-1: match -> LOCKED, am_v_o=1; non-match -> SEARCH, am_v_o=0, and that block is not re-examined as a new candidate.
REQ-022 LOCKED: expected-position block: match -> bad count cleared, am_v_o=1; non-match -> bad count +1, am_v_o=0.
REQ-023 LOCKED: bad count reaching AM_BAD_N -> SEARCH, lock_v_o falls and lock_lost_v_o pulses on the same output cycle.
REQ-024 Matches at non-expected positions in CONFIRM/LOCKED are ignored: am_v_o=0, counter unaffected.
REQ-025 lock_v_o rises on the output cycle after the confirming marker's am_v_o cycle and stays high while LOCKED.
REQ-026 valid_i low: counter and state hold, valid_o=0, am_v_o=0, data_o holds its last value.
REQ-027 block_lock_i low: -> SEARCH next cycle, counter and bad count cleared; if LOCKED, lock_lost_v_o pulses once; takes priority over any same-cycle match.
REQ-028 lock_lost_v_o never exceeds one cycle per lock loss; never asserted outside a LOCKED->SEARCH transition.

Reset
REQ-029 reset high: state SEARCH, counter 0, bad count 0, valid_o=0, am_v_o=0, lock_v_o=0, lock_lost_v_o=0, data_o=0.
REQ-030 reset asserted mid-lock clears lock_v_o immediately without a lock_lost_v_o pulse.

Verification (AM_PERIOD=16, LANE_ID=1, AM_BAD_N=4, valid_i and block_lock_i held high unless stated)
REQ-031 Reset mid-stream -> all outputs 0 asynchronously; first output cycle after release has valid_o=0.
REQ-032 Lane1 markers at input blocks 0 and 16 -> am_v_o at output cycles 1 and 17, lock_v_o high from cycle 18.
REQ-033 Marker at block 0, random data at block 16, markers at 20 and 36 -> am_v_o at 1, 21, 37; lock_v_o from 38.
REQ-034 Locked; 3 corrupted markers then good -> lock_v_o stays 1; 4 corrupted -> lock_lost_v_o 1 cycle at 4th expected slot+1, lock_v_o 0 that cycle.
REQ-035 valid_i low for 5 cycles between markers -> next marker still accepted 16 valid blocks later; am_v_o 0 during gaps.
REQ-036 Lane1 marker with random BIP bytes -> match; lane0 marker or header 2'b01 -> no match; block_lock_i drop while locked -> single lock_lost_v_o pulse.
